axi_xbar: RTL and testbench
===========================

AXI_XBAR -- requirements
Module: axi_xbar

Interface
REQ-001 The block SHALL have parameter NUM_M, default 2: number of master ports (1..4).
REQ-002 The block SHALL have parameter NUM_S, default 2: number of slave ports (1..4).
REQ-003 The block SHALL have parameters AXI_ADDR_BITS, default 32, and AXI_DATA_BITS, default 32: address and data widths.
REQ-004 The block SHALL have parameters SLV_BASE and SLV_MASK, each NUM_S*AXI_ADDR_BITS wide, giving per-slave base and mask.
- Defaults: S0 base 0x0000_0000, mask 0xFFFF_0000.
- Defaults: S1 base 0x0001_0000, mask 0xFFFF_0000.
REQ-005 The block SHALL have ACLK, input, 1: sole clock; all logic is rising-edge.
REQ-006 The block SHALL have ARESETn, input, 1: asynchronous, active-low reset.
REQ-007 Master read side: ARADDR_M, ARVALID_M, ARREADY_M, RDATA_M, RRESP_M, RVALID_M, RREADY_M, each packed NUM_M times its field width; directions as an AXI-Lite slave.
REQ-008 Master write side: AWADDR_M, AWVALID_M, AWREADY_M, WDATA_M, WSTRB_M, WVALID_M, WREADY_M, BRESP_M, BVALID_M, BREADY_M, each packed NUM_M times its field width; directions as an AXI-Lite slave.
REQ-009 Slave read side: ARADDR_S, ARVALID_S, ARREADY_S, RDATA_S, RRESP_S, RVALID_S, RREADY_S, each packed NUM_S times its field width; directions as an AXI-Lite master.
REQ-010 Slave write side: AWADDR_S, AWVALID_S, AWREADY_S, WDATA_S, WSTRB_S, WVALID_S, WREADY_S, BRESP_S, BVALID_S, BREADY_S, each packed NUM_S times its field width; directions as an AXI-Lite master.

Function
REQ-011 Address decode SHALL select slave s when (ADDR & SLV_MASK[s]) == SLV_BASE[s].
- On overlap, the lowest s wins.
- No match selects the internal error slave (ERR).
REQ-012 Each slave port and ERR SHALL have one independent read arbiter and one independent write arbiter.
- Arbiter states: IDLE -> GRANT -> IDLE.
REQ-013 In IDLE, the arbiter SHALL register a grant to the first requesting master in round-robin order, starting at the priority pointer.
- Read request: ARVALID with matching decode.
- Write request: AWVALID with matching decode.
- The grant takes effect the next cycle.
- Master-to-slave latency is therefore 1 cycle.
REQ-014 In GRANT, channels SHALL be forwarded combinationally between the granted master and the slave.
- Read grant: AR and R.
- Write grant: AW, W and B.
- Non-granted masters see READY=0 and VALID=0.
REQ-015 A read grant SHALL release on the R handshake (RVALID & RREADY); a write grant SHALL release on the B handshake.
- On release, the priority pointer becomes grantee+1 modulo NUM_M.
- The arbiter returns to IDLE.
- The next grant is issued no earlier than the following cycle.
REQ-016 Each master SHALL have at most one outstanding read and one outstanding write.
- A master's new AR is not accepted until its prior R handshake completes.
- A master's new AW is not accepted until its prior B handshake completes.
REQ-017 ERR SHALL accept AR/AW/W with READY=1 in GRANT.
- Read: the cycle after the AR handshake, assert RVALID with RRESP=2'b11 and RDATA=0, held until RREADY.
- Write: after both the AW and W handshakes, assert BVALID with BRESP=2'b11, held until BREADY.
REQ-018 AW and W MAY complete in either order; the write grant SHALL hold until both handshakes and the B handshake have completed.
REQ-019 Read and write arbiters SHALL operate concurrently.
- A master may hold a read grant on one slave and a write grant on another simultaneously.
REQ-020 The block SHALL NOT pass through RRESP/BRESP values other than those driven by the granted slave.
- The block SHALL NOT buffer data; throughput is 1 transaction per 2 cycles minimum per slave port.

Reset
REQ-021 While ARESETn=0, all grants SHALL clear, all arbiters SHALL enter IDLE and all priority pointers SHALL reset to 0.
- All VALID and READY outputs are 0.
- All data/addr/resp outputs are 0.
REQ-022 Reset asserted mid-transaction SHALL abort it immediately with no response issued.
- After deassertion, the first grant follows REQ-013 with pointer 0.

Verification
REQ-023 M0 reads 0x0000_0010 while S0 returns 0xDEADBEEF/OKAY -> ARVALID_S0 one cycle after ARVALID_M0; M0 receives 0xDEADBEEF with RRESP=0.
REQ-024 M0 and M1 both issue AR to 0x0001_0004 in the same cycle, from reset -> M0 granted first, then M1; pointer ends at 0; no overlap on S1.
REQ-025 M1 writes 0x0000_0020, data 0x12345678, WSTRB=4'hF, with W presented 2 cycles before AW -> S0 receives both; BRESP=0 returns to M1 only.
REQ-026 M0 reads 0x8000_0000 (unmapped) -> ARREADY_M0 asserted; RVALID_M0 asserted next cycle with RRESP=2'b11, RDATA=0; no slave port sees ARVALID.
REQ-027 Concurrent traffic: M0 reads S1 while M1 writes S0 -> both complete independently.
REQ-028 Reset pulse while S0 holds RVALID for M0 -> all outputs 0 during reset; post-reset M1 read to S0 completes normally.

Source files
------------

// File: rtl/axi_xbar.sv
// ---------------------------------------------------------------------------
// axi_xbar
//
// AXI-Lite crossbar connecting NUM_M masters to NUM_S slaves. Each master
// address is decoded against a per-slave base/mask pair. An address that
// matches no slave is routed to an internal error slave, which answers with
// DECERR (2'b11).
//
// Every target (each slave port plus the error slave) has two independent
// arbiters: one for reads and one for writes. Each arbiter is a two-state
// machine, IDLE -> GRANT -> IDLE, with round-robin priority across masters.
// A grant is registered in IDLE and takes effect on the next cycle. In GRANT
// the channels pass combinationally between the owner and the target. The
// grant is released on the R handshake (reads) or the B handshake (writes).
// The crossbar holds no data buffers.
//
// Ports (all buses are packed, index 0 in the least significant slice):
//   ACLK, ARESETn       clock (rising edge) and asynchronous active-low reset
//   *_M                 master-facing AXI-Lite slave ports, NUM_M wide
//                       AR/R: ARADDR_M ARVALID_M ARREADY_M RDATA_M RRESP_M
//                             RVALID_M RREADY_M
//                       AW/W/B: AWADDR_M AWVALID_M AWREADY_M WDATA_M WSTRB_M
//                             WVALID_M WREADY_M BRESP_M BVALID_M BREADY_M
//   *_S                 slave-facing AXI-Lite master ports, NUM_S wide,
//                       same channel set as the master side
// ---------------------------------------------------------------------------
module axi_xbar #(
    parameter int NUM_M         = 2,
    parameter int NUM_S         = 2,
    parameter int AXI_ADDR_BITS = 32,
    parameter int AXI_DATA_BITS = 32,
    parameter logic [NUM_S*AXI_ADDR_BITS-1:0] SLV_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_S*AXI_ADDR_BITS-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_0000}
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETn,
    // master read side
    input  logic [NUM_M*AXI_ADDR_BITS-1:0]         ARADDR_M,
    input  logic [NUM_M-1:0]                       ARVALID_M,
    output logic [NUM_M-1:0]                       ARREADY_M,
    output logic [NUM_M*AXI_DATA_BITS-1:0]         RDATA_M,
    output logic [NUM_M*2-1:0]                     RRESP_M,
    output logic [NUM_M-1:0]                       RVALID_M,
    input  logic [NUM_M-1:0]                       RREADY_M,
    // master write side
    input  logic [NUM_M*AXI_ADDR_BITS-1:0]         AWADDR_M,
    input  logic [NUM_M-1:0]                       AWVALID_M,
    output logic [NUM_M-1:0]                       AWREADY_M,
    input  logic [NUM_M*AXI_DATA_BITS-1:0]         WDATA_M,
    input  logic [NUM_M*(AXI_DATA_BITS/8)-1:0]     WSTRB_M,
    input  logic [NUM_M-1:0]                       WVALID_M,
    output logic [NUM_M-1:0]                       WREADY_M,
    output logic [NUM_M*2-1:0]                     BRESP_M,
    output logic [NUM_M-1:0]                       BVALID_M,
    input  logic [NUM_M-1:0]                       BREADY_M,
    // slave read side
    output logic [NUM_S*AXI_ADDR_BITS-1:0]         ARADDR_S,
    output logic [NUM_S-1:0]                       ARVALID_S,
    input  logic [NUM_S-1:0]                       ARREADY_S,
    input  logic [NUM_S*AXI_DATA_BITS-1:0]         RDATA_S,
    input  logic [NUM_S*2-1:0]                     RRESP_S,
    input  logic [NUM_S-1:0]                       RVALID_S,
    output logic [NUM_S-1:0]                       RREADY_S,
    // slave write side
    output logic [NUM_S*AXI_ADDR_BITS-1:0]         AWADDR_S,
    output logic [NUM_S-1:0]                       AWVALID_S,
    input  logic [NUM_S-1:0]                       AWREADY_S,
    output logic [NUM_S*AXI_DATA_BITS-1:0]         WDATA_S,
    output logic [NUM_S*(AXI_DATA_BITS/8)-1:0]     WSTRB_S,
    output logic [NUM_S-1:0]                       WVALID_S,
    input  logic [NUM_S-1:0]                       WREADY_S,
    input  logic [NUM_S*2-1:0]                     BRESP_S,
    input  logic [NUM_S-1:0]                       BVALID_S,
    output logic [NUM_S-1:0]                       BREADY_S
);

    localparam int NT  = NUM_S + 1;             // targets: slaves plus error slave
    localparam int ERR = NUM_S;                 // target index of the error slave
    localparam int MW  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int TW  = $clog2(NT);
    localparam int A   = AXI_ADDR_BITS;
    localparam int D   = AXI_DATA_BITS;
    localparam int SB  = AXI_DATA_BITS / 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // arbiter state, one entry per target
    logic [0:0]    rd_state   [NT];
    logic [MW-1:0] rd_owner   [NT];
    logic [MW-1:0] rd_ptr     [NT];
    logic          rd_ar_done [NT];
    logic [0:0]    wr_state   [NT];
    logic [MW-1:0] wr_owner   [NT];
    logic [MW-1:0] wr_ptr     [NT];
    logic          wr_aw_done [NT];
    logic          wr_w_done  [NT];

    // error slave response registers
    logic err_rvalid;
    logic err_bvalid;

    // decode and request vectors
    logic [TW-1:0]    ar_sel [NUM_M];
    logic [TW-1:0]    aw_sel [NUM_M];
    logic [NUM_M-1:0] rd_busy;
    logic [NUM_M-1:0] wr_busy;
    logic [NUM_M-1:0] rd_req [NT];
    logic [NUM_M-1:0] wr_req [NT];

    // uniform target-side view: slave ports and the error slave look alike
    logic          t_arready [NT];
    logic          t_rvalid  [NT];
    logic [D-1:0]  t_rdata   [NT];
    logic [1:0]    t_rresp   [NT];
    logic          t_awready [NT];
    logic          t_wready  [NT];
    logic          t_bvalid  [NT];
    logic [1:0]    t_bresp   [NT];

    // per-target handshakes seen through the crossbar
    logic ar_hs [NT];
    logic r_hs  [NT];
    logic aw_hs [NT];
    logic w_hs  [NT];
    logic b_hs  [NT];
    logic wr_release [NT];

    // Lowest slave index wins on overlap, so scan downward and let the
    // last match stand. No match leaves the error slave selected.
    function automatic logic [TW-1:0] decode(input logic [A-1:0] addr);
        logic [TW-1:0] sel;
        sel = TW'(ERR);
        for (int s = NUM_S - 1; s >= 0; s--) begin
            if ((addr & SLV_MASK[s*A +: A]) == SLV_BASE[s*A +: A])
                sel = TW'(s);
        end
        return sel;
    endfunction

    // First requester at or after the priority pointer, wrapping around.
    function automatic logic [MW-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                              input logic [MW-1:0]    ptr);
        logic [MW-1:0] pick;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            idx = (int'(ptr) + k) % NUM_M;
            if (!found && req[idx]) begin
                pick  = MW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [MW-1:0] rr_next(input logic [MW-1:0] owner);
        return MW'((int'(owner) + 1) % NUM_M);
    endfunction

    // A master that already owns a read (write) grant anywhere stops
    // requesting until that grant releases. This gives each master at most
    // one outstanding read and one outstanding write.
    always_comb begin
        rd_busy = '0;
        wr_busy = '0;
        for (int t = 0; t < NT; t++) begin
            if (rd_state[t] == ST_GRANT) rd_busy[rd_owner[t]] = 1'b1;
            if (wr_state[t] == ST_GRANT) wr_busy[wr_owner[t]] = 1'b1;
        end
        for (int m = 0; m < NUM_M; m++) begin
            ar_sel[m] = decode(ARADDR_M[m*A +: A]);
            aw_sel[m] = decode(AWADDR_M[m*A +: A]);
        end
        for (int t = 0; t < NT; t++) begin
            rd_req[t] = '0;
            wr_req[t] = '0;
            for (int m = 0; m < NUM_M; m++) begin
                rd_req[t][m] = ARVALID_M[m] && !rd_busy[m] && (ar_sel[m] == TW'(t));
                wr_req[t][m] = AWVALID_M[m] && !wr_busy[m] && (aw_sel[m] == TW'(t));
            end
        end
    end

    // Target-side view. The error slave is always ready; the routing logic
    // only uses its readiness while granted, and only until each
    // handshake is done.
    always_comb begin
        for (int s = 0; s < NUM_S; s++) begin
            t_arready[s] = ARREADY_S[s];
            t_rvalid[s]  = RVALID_S[s];
            t_rdata[s]   = RDATA_S[s*D +: D];
            t_rresp[s]   = RRESP_S[s*2 +: 2];
            t_awready[s] = AWREADY_S[s];
            t_wready[s]  = WREADY_S[s];
            t_bvalid[s]  = BVALID_S[s];
            t_bresp[s]   = BRESP_S[s*2 +: 2];
        end
        t_arready[ERR] = 1'b1;
        t_rvalid[ERR]  = err_rvalid;
        t_rdata[ERR]   = '0;
        t_rresp[ERR]   = err_rvalid ? 2'b11 : 2'b00;
        t_awready[ERR] = 1'b1;
        t_wready[ERR]  = 1'b1;
        t_bvalid[ERR]  = err_bvalid;
        t_bresp[ERR]   = err_bvalid ? 2'b11 : 2'b00;
    end

    // Master-side routing and handshake detection. Only the owner of a
    // grant sees anything from a target; everything else stays 0. AR, AW and
    // W are masked once their handshake is done. This prevents a master's
    // follow-on request from reaching the target too early.
    always_comb begin
        int   m;
        logic ar_vld, ar_rdy, aw_vld, aw_rdy, w_vld, w_rdy;
        m = 0;
        ar_vld = 1'b0; ar_rdy = 1'b0;
        aw_vld = 1'b0; aw_rdy = 1'b0;
        w_vld  = 1'b0; w_rdy  = 1'b0;
        ARREADY_M = '0;
        RDATA_M   = '0;
        RRESP_M   = '0;
        RVALID_M  = '0;
        AWREADY_M = '0;
        WREADY_M  = '0;
        BRESP_M   = '0;
        BVALID_M  = '0;
        for (int t = 0; t < NT; t++) begin
            ar_hs[t] = 1'b0;
            r_hs[t]  = 1'b0;
            aw_hs[t] = 1'b0;
            w_hs[t]  = 1'b0;
            b_hs[t]  = 1'b0;
            wr_release[t] = 1'b0;
            if (rd_state[t] == ST_GRANT) begin
                m      = int'(rd_owner[t]);
                ar_vld = ARVALID_M[m] && !rd_ar_done[t];
                ar_rdy = t_arready[t] && !rd_ar_done[t];
                ARREADY_M[m]        = ar_rdy;
                RVALID_M[m]         = t_rvalid[t];
                RDATA_M[m*D +: D]   = t_rdata[t];
                RRESP_M[m*2 +: 2]   = t_rresp[t];
                ar_hs[t] = ar_vld && ar_rdy;
                r_hs[t]  = t_rvalid[t] && RREADY_M[m];
            end
            if (wr_state[t] == ST_GRANT) begin
                m      = int'(wr_owner[t]);
                aw_vld = AWVALID_M[m] && !wr_aw_done[t];
                aw_rdy = t_awready[t] && !wr_aw_done[t];
                w_vld  = WVALID_M[m] && !wr_w_done[t];
                w_rdy  = t_wready[t] && !wr_w_done[t];
                AWREADY_M[m]      = aw_rdy;
                WREADY_M[m]       = w_rdy;
                BVALID_M[m]       = t_bvalid[t];
                BRESP_M[m*2 +: 2] = t_bresp[t];
                aw_hs[t] = aw_vld && aw_rdy;
                w_hs[t]  = w_vld && w_rdy;
                b_hs[t]  = t_bvalid[t] && BREADY_M[m];
                wr_release[t] = b_hs[t] && (wr_aw_done[t] || aw_hs[t])
                                        && (wr_w_done[t]  || w_hs[t]);
            end
        end
    end

    // Slave-side routing: forward the owner's request channels to each
    // real slave port.
    always_comb begin
        ARADDR_S  = '0;
        ARVALID_S = '0;
        RREADY_S  = '0;
        AWADDR_S  = '0;
        AWVALID_S = '0;
        WDATA_S   = '0;
        WSTRB_S   = '0;
        WVALID_S  = '0;
        BREADY_S  = '0;
        for (int s = 0; s < NUM_S; s++) begin
            if (rd_state[s] == ST_GRANT) begin
                ARADDR_S[s*A +: A] = ARADDR_M[int'(rd_owner[s])*A +: A];
                ARVALID_S[s]       = ARVALID_M[rd_owner[s]] && !rd_ar_done[s];
                RREADY_S[s]        = RREADY_M[rd_owner[s]];
            end
            if (wr_state[s] == ST_GRANT) begin
                AWADDR_S[s*A +: A]  = AWADDR_M[int'(wr_owner[s])*A +: A];
                AWVALID_S[s]        = AWVALID_M[wr_owner[s]] && !wr_aw_done[s];
                WDATA_S[s*D +: D]   = WDATA_M[int'(wr_owner[s])*D +: D];
                WSTRB_S[s*SB +: SB] = WSTRB_M[int'(wr_owner[s])*SB +: SB];
                WVALID_S[s]         = WVALID_M[wr_owner[s]] && !wr_w_done[s];
                BREADY_S[s]         = BREADY_M[wr_owner[s]];
            end
        end
    end

    // Arbiter state machines and error-slave responses. Reset aborts any
    // transaction in flight without producing a response.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int t = 0; t < NT; t++) begin
                rd_state[t]   <= ST_IDLE;
                rd_owner[t]   <= '0;
                rd_ptr[t]     <= '0;
                rd_ar_done[t] <= 1'b0;
                wr_state[t]   <= ST_IDLE;
                wr_owner[t]   <= '0;
                wr_ptr[t]     <= '0;
                wr_aw_done[t] <= 1'b0;
                wr_w_done[t]  <= 1'b0;
            end
            err_rvalid <= 1'b0;
            err_bvalid <= 1'b0;
        end else begin
            for (int t = 0; t < NT; t++) begin
                if (rd_state[t] == ST_IDLE) begin
                    if (|rd_req[t]) begin
                        rd_state[t]   <= ST_GRANT;
                        rd_owner[t]   <= rr_pick(rd_req[t], rd_ptr[t]);
                        rd_ar_done[t] <= 1'b0;
                    end
                end else begin
                    if (ar_hs[t]) rd_ar_done[t] <= 1'b1;
                    if (r_hs[t]) begin
                        rd_state[t]   <= ST_IDLE;
                        rd_ptr[t]     <= rr_next(rd_owner[t]);
                        rd_ar_done[t] <= 1'b0;
                    end
                end

                if (wr_state[t] == ST_IDLE) begin
                    if (|wr_req[t]) begin
                        wr_state[t]   <= ST_GRANT;
                        wr_owner[t]   <= rr_pick(wr_req[t], wr_ptr[t]);
                        wr_aw_done[t] <= 1'b0;
                        wr_w_done[t]  <= 1'b0;
                    end
                end else begin
                    if (aw_hs[t]) wr_aw_done[t] <= 1'b1;
                    if (w_hs[t])  wr_w_done[t]  <= 1'b1;
                    if (wr_release[t]) begin
                        wr_state[t]   <= ST_IDLE;
                        wr_ptr[t]     <= rr_next(wr_owner[t]);
                        wr_aw_done[t] <= 1'b0;
                        wr_w_done[t]  <= 1'b0;
                    end
                end
            end

            // error read response appears the cycle after the AR handshake
            if (r_hs[ERR])
                err_rvalid <= 1'b0;
            else if (ar_hs[ERR])
                err_rvalid <= 1'b1;

            // error write response waits for both AW and W, in either order
            if (b_hs[ERR])
                err_bvalid <= 1'b0;
            else if (wr_state[ERR] == ST_GRANT && !err_bvalid
                     && (wr_aw_done[ERR] || aw_hs[ERR])
                     && (wr_w_done[ERR]  || w_hs[ERR]))
                err_bvalid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_xbar.sv
// ---------------------------------------------------------------------------
// tb_axi_xbar
//
// Directed testbench for axi_xbar with the default configuration: 2 masters,
// 2 slaves, S0 at 0x0000_xxxx and S1 at 0x0001_xxxx. The bench itself plays
// both the masters and the slaves. It drives inputs on the falling edge and
// samples outputs 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_axi_xbar;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [63:0] ARADDR_M;  logic [1:0] ARVALID_M, ARREADY_M;
    logic [63:0] RDATA_M;   logic [3:0] RRESP_M;   logic [1:0] RVALID_M, RREADY_M;
    logic [63:0] AWADDR_M;  logic [1:0] AWVALID_M, AWREADY_M;
    logic [63:0] WDATA_M;   logic [7:0] WSTRB_M;   logic [1:0] WVALID_M, WREADY_M;
    logic [3:0]  BRESP_M;   logic [1:0] BVALID_M, BREADY_M;
    logic [63:0] ARADDR_S;  logic [1:0] ARVALID_S, ARREADY_S;
    logic [63:0] RDATA_S;   logic [3:0] RRESP_S;   logic [1:0] RVALID_S, RREADY_S;
    logic [63:0] AWADDR_S;  logic [1:0] AWVALID_S, AWREADY_S;
    logic [63:0] WDATA_S;   logic [7:0] WSTRB_S;   logic [1:0] WVALID_S, WREADY_S;
    logic [3:0]  BRESP_S;   logic [1:0] BVALID_S, BREADY_S;

    int tests_run    = 0;
    int tests_failed = 0;

    axi_xbar #(.NUM_M(2), .NUM_S(2), .AXI_ADDR_BITS(32), .AXI_DATA_BITS(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARADDR_M(ARADDR_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWADDR_M(AWADDR_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WVALID_M(WVALID_M), .WREADY_M(WREADY_M),
        .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
        .ARADDR_S(ARADDR_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .AWADDR_S(AWADDR_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S)
    );

    always #5 ACLK = ~ACLK;

    task automatic clear_inputs();
        ARADDR_M = '0; ARVALID_M = '0; RREADY_M = '0;
        AWADDR_M = '0; AWVALID_M = '0; WDATA_M = '0; WSTRB_M = '0; WVALID_M = '0; BREADY_M = '0;
        ARREADY_S = '0; RDATA_S = '0; RRESP_S = '0; RVALID_S = '0;
        AWREADY_S = '0; WREADY_S = '0; BRESP_S = '0; BVALID_S = '0;
    endtask

    // leaves the bench on a falling edge with reset just released
    task automatic do_reset();
        @(negedge ACLK);
        clear_inputs();
        ARESETn = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        ARESETn   = 1'b0;
        ARVALID_M = 2'b11; AWVALID_M = 2'b11; WVALID_M = 2'b11;
        ARREADY_S = 2'b11; RVALID_S = 2'b11; RDATA_S = 64'hFFFF_FFFF_FFFF_FFFF;
        RRESP_S = 4'hF; BVALID_S = 2'b11; BRESP_S = 4'hF;
        #1;
        tests_run++; if (ARREADY_M !== 2'b00 || RVALID_M !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_m_rd: ARREADY_M=%b RVALID_M=%b expected 00 00", ARREADY_M, RVALID_M); end
        @(negedge ACLK); @(negedge ACLK); #1;
        tests_run++; if ({AWREADY_M, WREADY_M, BVALID_M} !== 6'b0) begin tests_failed++; $display("[TB] FAIL reset_m_wr: AWREADY/WREADY/BVALID=%b expected 0", {AWREADY_M, WREADY_M, BVALID_M}); end
        tests_run++; if ({ARVALID_S, AWVALID_S, WVALID_S, RREADY_S, BREADY_S} !== 10'b0) begin tests_failed++; $display("[TB] FAIL reset_s_ctl: got %b expected 0", {ARVALID_S, AWVALID_S, WVALID_S, RREADY_S, BREADY_S}); end
        tests_run++; if ({RDATA_M, RRESP_M, BRESP_M} !== 72'b0) begin tests_failed++; $display("[TB] FAIL reset_data: RDATA_M=%h RRESP_M=%h BRESP_M=%h expected 0", RDATA_M, RRESP_M, BRESP_M); end
        clear_inputs();
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    task automatic test_read_basic();
        do_reset();
        ARADDR_M[31:0] = 32'h0000_0010; ARVALID_M[0] = 1'b1; #1;
        tests_run++; if (ARVALID_S !== 2'b00) begin tests_failed++; $display("[TB] FAIL rd_pre_grant: ARVALID_S=%b expected 00", ARVALID_S); end
        @(negedge ACLK); #1;
        tests_run++; if (ARVALID_S !== 2'b01) begin tests_failed++; $display("[TB] FAIL rd_latency: ARVALID_S=%b expected 01", ARVALID_S); end
        tests_run++; if (ARADDR_S[31:0] !== 32'h0000_0010) begin tests_failed++; $display("[TB] FAIL rd_addr: ARADDR_S0=%h expected 00000010", ARADDR_S[31:0]); end
        tests_run++; if (ARREADY_M !== 2'b00) begin tests_failed++; $display("[TB] FAIL rd_arready_wait: ARREADY_M=%b expected 00", ARREADY_M); end
        ARREADY_S[0] = 1'b1; #1;
        tests_run++; if (ARREADY_M !== 2'b01) begin tests_failed++; $display("[TB] FAIL rd_arready: ARREADY_M=%b expected 01", ARREADY_M); end
        @(negedge ACLK);
        ARVALID_M = '0; ARREADY_S = '0;
        RVALID_S[0] = 1'b1; RDATA_S[31:0] = 32'hDEAD_BEEF; RRESP_S[1:0] = 2'b00; RREADY_M[0] = 1'b1; #1;
        tests_run++; if (RVALID_M !== 2'b01) begin tests_failed++; $display("[TB] FAIL rd_rvalid: RVALID_M=%b expected 01", RVALID_M); end
        tests_run++; if (RDATA_M !== 64'h0000_0000_DEAD_BEEF) begin tests_failed++; $display("[TB] FAIL rd_rdata: RDATA_M=%h expected 00000000deadbeef", RDATA_M); end
        tests_run++; if (RRESP_M !== 4'b0000) begin tests_failed++; $display("[TB] FAIL rd_rresp: RRESP_M=%b expected 0000", RRESP_M); end
        @(negedge ACLK);
        RVALID_S = '0; RDATA_S = '0; #1;
        tests_run++; if (RVALID_M !== 2'b00 || ARVALID_S !== 2'b00) begin tests_failed++; $display("[TB] FAIL rd_release: RVALID_M=%b ARVALID_S=%b expected 00 00", RVALID_M, ARVALID_S); end
    endtask

    task automatic test_round_robin();
        do_reset();
        ARADDR_M = {32'h0001_0004, 32'h0001_0004}; ARVALID_M = 2'b11; ARREADY_S[1] = 1'b1; RREADY_M = 2'b11;
        @(negedge ACLK); #1;
        tests_run++; if (ARREADY_M !== 2'b01 || ARVALID_S !== 2'b10) begin tests_failed++; $display("[TB] FAIL rr_first_m0: ARREADY_M=%b ARVALID_S=%b expected 01 10", ARREADY_M, ARVALID_S); end
        tests_run++; if (ARADDR_S[63:32] !== 32'h0001_0004) begin tests_failed++; $display("[TB] FAIL rr_addr: ARADDR_S1=%h expected 00010004", ARADDR_S[63:32]); end
        @(negedge ACLK);
        ARVALID_M[0] = 1'b0; #1;
        tests_run++; if (ARVALID_S !== 2'b00 || ARREADY_M !== 2'b00) begin tests_failed++; $display("[TB] FAIL rr_no_overlap: ARVALID_S=%b ARREADY_M=%b expected 00 00", ARVALID_S, ARREADY_M); end
        RVALID_S[1] = 1'b1; RDATA_S[63:32] = 32'hAAAA_0000; #1;
        tests_run++; if (RVALID_M !== 2'b01 || RDATA_M[31:0] !== 32'hAAAA_0000) begin tests_failed++; $display("[TB] FAIL rr_r_m0: RVALID_M=%b RDATA_M0=%h expected 01 aaaa0000", RVALID_M, RDATA_M[31:0]); end
        @(negedge ACLK);
        RVALID_S = '0; #1;
        tests_run++; if (ARVALID_S !== 2'b00 || ARREADY_M !== 2'b00) begin tests_failed++; $display("[TB] FAIL rr_idle_gap: ARVALID_S=%b ARREADY_M=%b expected 00 00", ARVALID_S, ARREADY_M); end
        @(negedge ACLK); #1;
        tests_run++; if (ARREADY_M !== 2'b10 || ARVALID_S !== 2'b10) begin tests_failed++; $display("[TB] FAIL rr_second_m1: ARREADY_M=%b ARVALID_S=%b expected 10 10", ARREADY_M, ARVALID_S); end
        @(negedge ACLK);
        ARVALID_M = '0; RVALID_S[1] = 1'b1; RDATA_S[63:32] = 32'hBBBB_1111; #1;
        tests_run++; if (RVALID_M !== 2'b10 || RDATA_M[63:32] !== 32'hBBBB_1111) begin tests_failed++; $display("[TB] FAIL rr_r_m1: RVALID_M=%b RDATA_M1=%h expected 10 bbbb1111", RVALID_M, RDATA_M[63:32]); end
        @(negedge ACLK);
        RVALID_S = '0; ARVALID_M = 2'b11;
        @(negedge ACLK); #1;
        tests_run++; if (ARREADY_M !== 2'b01) begin tests_failed++; $display("[TB] FAIL rr_ptr_wrap: ARREADY_M=%b expected 01", ARREADY_M); end
    endtask

    task automatic test_write_w_first();
        do_reset();
        WDATA_M[63:32] = 32'h1234_5678; WSTRB_M[7:4] = 4'hF; WVALID_M[1] = 1'b1;
        AWREADY_S[0] = 1'b1; WREADY_S[0] = 1'b1; BREADY_M = 2'b11; #1;
        tests_run++; if (WVALID_S !== 2'b00 || WREADY_M !== 2'b00) begin tests_failed++; $display("[TB] FAIL wr_w_early: WVALID_S=%b WREADY_M=%b expected 00 00", WVALID_S, WREADY_M); end
        @(negedge ACLK); @(negedge ACLK);
        AWADDR_M[63:32] = 32'h0000_0020; AWVALID_M[1] = 1'b1; #1;
        tests_run++; if (AWVALID_S !== 2'b00) begin tests_failed++; $display("[TB] FAIL wr_pre_grant: AWVALID_S=%b expected 00", AWVALID_S); end
        @(negedge ACLK); #1;
        tests_run++; if (AWVALID_S !== 2'b01 || AWADDR_S[31:0] !== 32'h0000_0020) begin tests_failed++; $display("[TB] FAIL wr_aw: AWVALID_S=%b AWADDR_S0=%h expected 01 00000020", AWVALID_S, AWADDR_S[31:0]); end
        tests_run++; if (WVALID_S !== 2'b01 || WDATA_S[31:0] !== 32'h1234_5678 || WSTRB_S[3:0] !== 4'hF) begin tests_failed++; $display("[TB] FAIL wr_w: WVALID_S=%b WDATA_S0=%h WSTRB_S0=%h expected 01 12345678 f", WVALID_S, WDATA_S[31:0], WSTRB_S[3:0]); end
        tests_run++; if (AWREADY_M !== 2'b10 || WREADY_M !== 2'b10) begin tests_failed++; $display("[TB] FAIL wr_ready: AWREADY_M=%b WREADY_M=%b expected 10 10", AWREADY_M, WREADY_M); end
        @(negedge ACLK);
        AWVALID_M = '0; WVALID_M = '0; BVALID_S[0] = 1'b1; BRESP_S[1:0] = 2'b00; #1;
        tests_run++; if (AWVALID_S !== 2'b00 || WVALID_S !== 2'b00) begin tests_failed++; $display("[TB] FAIL wr_done: AWVALID_S=%b WVALID_S=%b expected 00 00", AWVALID_S, WVALID_S); end
        tests_run++; if (BVALID_M !== 2'b10 || BRESP_M !== 4'b0000) begin tests_failed++; $display("[TB] FAIL wr_b_m1: BVALID_M=%b BRESP_M=%b expected 10 0000", BVALID_M, BRESP_M); end
        @(negedge ACLK);
        BVALID_S = '0; #1;
        tests_run++; if (BVALID_M !== 2'b00 || BREADY_S !== 2'b00) begin tests_failed++; $display("[TB] FAIL wr_release: BVALID_M=%b BREADY_S=%b expected 00 00", BVALID_M, BREADY_S); end
    endtask

    task automatic test_error_slave();
        do_reset();
        ARADDR_M[31:0] = 32'h8000_0000; ARVALID_M[0] = 1'b1; ARREADY_S = 2'b11;
        @(negedge ACLK); #1;
        tests_run++; if (ARREADY_M !== 2'b01 || ARVALID_S !== 2'b00) begin tests_failed++; $display("[TB] FAIL err_ar: ARREADY_M=%b ARVALID_S=%b expected 01 00", ARREADY_M, ARVALID_S); end
        tests_run++; if (RVALID_M !== 2'b00) begin tests_failed++; $display("[TB] FAIL err_r_early: RVALID_M=%b expected 00", RVALID_M); end
        @(negedge ACLK);
        ARVALID_M = '0; #1;
        tests_run++; if (RVALID_M !== 2'b01 || RRESP_M[1:0] !== 2'b11 || RDATA_M[31:0] !== 32'h0) begin tests_failed++; $display("[TB] FAIL err_r: RVALID_M=%b RRESP_M0=%b RDATA_M0=%h expected 01 11 0", RVALID_M, RRESP_M[1:0], RDATA_M[31:0]); end
        @(negedge ACLK); #1;
        tests_run++; if (RVALID_M !== 2'b01 || ARVALID_S !== 2'b00) begin tests_failed++; $display("[TB] FAIL err_r_hold: RVALID_M=%b ARVALID_S=%b expected 01 00", RVALID_M, ARVALID_S); end
        RREADY_M[0] = 1'b1;
        @(negedge ACLK); #1;
        tests_run++; if (RVALID_M !== 2'b00) begin tests_failed++; $display("[TB] FAIL err_r_release: RVALID_M=%b expected 00", RVALID_M); end
        AWADDR_M[63:32] = 32'h9000_0000; AWVALID_M[1] = 1'b1; WVALID_M[1] = 1'b1; WDATA_M[63:32] = 32'h5A5A_5A5A;
        AWREADY_S = 2'b11; WREADY_S = 2'b11;
        @(negedge ACLK); #1;
        tests_run++; if (AWREADY_M !== 2'b10 || WREADY_M !== 2'b10 || AWVALID_S !== 2'b00 || WVALID_S !== 2'b00) begin tests_failed++; $display("[TB] FAIL err_aw_w: AWREADY_M=%b WREADY_M=%b AWVALID_S=%b WVALID_S=%b expected 10 10 00 00", AWREADY_M, WREADY_M, AWVALID_S, WVALID_S); end
        @(negedge ACLK);
        AWVALID_M = '0; WVALID_M = '0; BREADY_M[1] = 1'b1; #1;
        tests_run++; if (BVALID_M !== 2'b10 || BRESP_M[3:2] !== 2'b11) begin tests_failed++; $display("[TB] FAIL err_b: BVALID_M=%b BRESP_M1=%b expected 10 11", BVALID_M, BRESP_M[3:2]); end
        @(negedge ACLK); #1;
        tests_run++; if (BVALID_M !== 2'b00) begin tests_failed++; $display("[TB] FAIL err_b_release: BVALID_M=%b expected 00", BVALID_M); end
    endtask

    task automatic test_concurrent();
        do_reset();
        ARADDR_M[31:0] = 32'h0001_0008; ARVALID_M[0] = 1'b1;
        AWADDR_M[63:32] = 32'h0000_0030; AWVALID_M[1] = 1'b1;
        WDATA_M[63:32] = 32'hCAFE_F00D; WSTRB_M[7:4] = 4'h3; WVALID_M[1] = 1'b1;
        ARREADY_S = 2'b11; AWREADY_S = 2'b11; WREADY_S = 2'b11;
        @(negedge ACLK); #1;
        tests_run++; if (ARVALID_S !== 2'b10 || AWVALID_S !== 2'b01 || WVALID_S !== 2'b01) begin tests_failed++; $display("[TB] FAIL conc_req: ARVALID_S=%b AWVALID_S=%b WVALID_S=%b expected 10 01 01", ARVALID_S, AWVALID_S, WVALID_S); end
        tests_run++; if (ARREADY_M !== 2'b01 || AWREADY_M !== 2'b10 || WSTRB_S[3:0] !== 4'h3) begin tests_failed++; $display("[TB] FAIL conc_ready: ARREADY_M=%b AWREADY_M=%b WSTRB_S0=%h expected 01 10 3", ARREADY_M, AWREADY_M, WSTRB_S[3:0]); end
        @(negedge ACLK);
        ARVALID_M = '0; AWVALID_M = '0; WVALID_M = '0;
        RVALID_S[1] = 1'b1; RDATA_S[63:32] = 32'h5555_AAAA; BVALID_S[0] = 1'b1;
        RREADY_M = 2'b11; BREADY_M = 2'b11; #1;
        tests_run++; if (RVALID_M !== 2'b01 || RDATA_M[31:0] !== 32'h5555_AAAA || BVALID_M !== 2'b10) begin tests_failed++; $display("[TB] FAIL conc_resp: RVALID_M=%b RDATA_M0=%h BVALID_M=%b expected 01 5555aaaa 10", RVALID_M, RDATA_M[31:0], BVALID_M); end
        @(negedge ACLK);
        RVALID_S = '0; BVALID_S = '0; #1;
        tests_run++; if (RVALID_M !== 2'b00 || BVALID_M !== 2'b00) begin tests_failed++; $display("[TB] FAIL conc_release: RVALID_M=%b BVALID_M=%b expected 00 00", RVALID_M, BVALID_M); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ARADDR_M[31:0] = 32'h0000_0040; ARVALID_M[0] = 1'b1; ARREADY_S[0] = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        ARVALID_M = '0; ARREADY_S = '0; RVALID_S[0] = 1'b1; RDATA_S[31:0] = 32'h1111_2222; #1;
        tests_run++; if (RVALID_M !== 2'b01 || RDATA_M[31:0] !== 32'h1111_2222) begin tests_failed++; $display("[TB] FAIL mid_r_pending: RVALID_M=%b RDATA_M0=%h expected 01 11112222", RVALID_M, RDATA_M[31:0]); end
        ARESETn = 1'b0;
        ARADDR_M[63:32] = 32'h0000_0050; ARVALID_M[1] = 1'b1; ARREADY_S[0] = 1'b1; #1;
        tests_run++; if (RVALID_M !== 2'b00 || RDATA_M !== 64'h0 || ARREADY_M !== 2'b00) begin tests_failed++; $display("[TB] FAIL mid_abort: RVALID_M=%b RDATA_M=%h ARREADY_M=%b expected 00 0 00", RVALID_M, RDATA_M, ARREADY_M); end
        @(negedge ACLK); #1;
        tests_run++; if (ARVALID_S !== 2'b00 || ARADDR_S !== 64'h0 || RREADY_S !== 2'b00) begin tests_failed++; $display("[TB] FAIL mid_in_reset: ARVALID_S=%b ARADDR_S=%h RREADY_S=%b expected 00 0 00", ARVALID_S, ARADDR_S, RREADY_S); end
        RVALID_S = '0; RDATA_S = '0; ARESETn = 1'b1;
        @(negedge ACLK); #1;
        tests_run++; if (ARVALID_S !== 2'b01 || ARADDR_S[31:0] !== 32'h0000_0050 || ARREADY_M !== 2'b10) begin tests_failed++; $display("[TB] FAIL mid_post_grant: ARVALID_S=%b ARADDR_S0=%h ARREADY_M=%b expected 01 00000050 10", ARVALID_S, ARADDR_S[31:0], ARREADY_M); end
        @(negedge ACLK);
        ARVALID_M = '0; ARREADY_S = '0; RVALID_S[0] = 1'b1; RDATA_S[31:0] = 32'h3333_4444; RREADY_M[1] = 1'b1; #1;
        tests_run++; if (RVALID_M !== 2'b10 || RDATA_M[63:32] !== 32'h3333_4444) begin tests_failed++; $display("[TB] FAIL mid_post_r: RVALID_M=%b RDATA_M1=%h expected 10 33334444", RVALID_M, RDATA_M[63:32]); end
        @(negedge ACLK);
        RVALID_S = '0; #1;
        tests_run++; if (RVALID_M !== 2'b00) begin tests_failed++; $display("[TB] FAIL mid_post_release: RVALID_M=%b expected 00", RVALID_M); end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_round_robin();
        test_write_w_first();
        test_error_slave();
        test_concurrent();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion before 100000");
        $fatal(1, "[TB] timeout");
    end

endmodule
